// File: rtl/conv_writeback_pkg.sv
// -----------------------------------------------------------------------------
// conv_writeback_pkg
//   Shared definitions for the convolution write-back path: default datapath
//   widths, the write-back FSM state encoding and the output saturation
//   limits (the same limits the Accel block clips against).
// -----------------------------------------------------------------------------
package conv_writeback_pkg;

  // Default datapath widths
  localparam int ACC_W_DEF  = 18;  // accumulator / bias width (signed)
  localparam int DATA_W_DEF = 16;  // memory word width (signed result)
  localparam int ADDR_W_DEF = 16;  // memory address width

  // Signed saturation limits for a DATA_W_DEF-bit result
  localparam int SAT_MAX = (2 ** (DATA_W_DEF - 1)) - 1;
  localparam int SAT_MIN = -(2 ** (DATA_W_DEF - 1));

  // Write-back frame sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // waiting for start
    ST_RUN   = 2'd1,  // accepting pixels from the result stream
    ST_DRAIN = 2'd2,  // last pixel taken, final write still pending
    ST_FIN   = 2'd3   // one-cycle done pulse
  } wb_state_e;

endpackage : conv_writeback_pkg

// File: rtl/wb_bias_relu_sat.sv
// -----------------------------------------------------------------------------
// wb_bias_relu_sat
//   Combinational pixel post-processing: adds a signed bias to a signed
//   accumulator value at full precision (one extra bit, cannot overflow),
//   optionally clamps negative sums to zero, then saturates to a signed
//   DATA_W-bit word.
// Ports
//   acc      in   ACC_W   signed accumulator value
//   bias     in   ACC_W   signed bias
//   relu_en  in   1       1 = negative sums become 0
//   pix      out  DATA_W  saturated signed result
// -----------------------------------------------------------------------------
module wb_bias_relu_sat
  import conv_writeback_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [ACC_W-1:0]  bias,
  input  logic                     relu_en,
  output logic signed [DATA_W-1:0] pix
);

  localparam int SUM_W = ACC_W + 1;

  // Saturation bounds expressed at sum width so the compare stays signed.
  localparam logic signed [SUM_W-1:0] LIM_MAX =
    {{(SUM_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [SUM_W-1:0] LIM_MIN =
    {{(SUM_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] clip;

  always_comb begin
    // Explicit sign extension: both operands widened before the add.
    sum  = {acc[ACC_W-1], acc} + {bias[ACC_W-1], bias};
    clip = sum;
    if (relu_en && sum[SUM_W-1]) begin
      clip = '0;
    end

    if (clip > LIM_MAX) begin
      pix = LIM_MAX[DATA_W-1:0];
    end else if (clip < LIM_MIN) begin
      pix = LIM_MIN[DATA_W-1:0];
    end else begin
      pix = clip[DATA_W-1:0];
    end
  end

endmodule : wb_bias_relu_sat

// File: rtl/conv_writeback.sv
// -----------------------------------------------------------------------------
// conv_writeback
//   Output side of the convolution datapath. Takes the Accel result stream
//   (one signed accumulator value per output pixel, raster order), applies
//   bias / optional ReLU / saturation and writes each pixel to memory at
//   consecutive addresses starting from out_memory_offset. done pulses for
//   one cycle once the final write has been accepted by memory.
// Ports
//   clk, rst            clock / asynchronous active-high reset
//   start               1-cycle pulse, accepted only when idle; latches config
//   out_dim             frame side length (out_dim x out_dim pixels)
//   out_memory_offset   address of pixel (0,0)
//   filter_bias         signed bias added to every pixel
//   relu_en             clamp negative sums to 0
//   in_valid/in_data/in_ready      result stream handshake
//   mem_we/mem_addr/mem_wdata/mem_ready  memory write handshake
//   busy                high while a frame is in progress
//   done                1-cycle pulse at frame completion
// -----------------------------------------------------------------------------
module conv_writeback
  import conv_writeback_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        out_dim,
  input  logic [ADDR_W-1:0] out_memory_offset,
  input  logic [ACC_W-1:0]  filter_bias,
  input  logic              relu_en,
  input  logic              in_valid,
  input  logic [ACC_W-1:0]  in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done
);

  wb_state_e         state_q, state_d;
  logic [7:0]        dim_q, dim_d;
  logic [ACC_W-1:0]  bias_q, bias_d;
  logic              relu_q, relu_d;
  logic [7:0]        col_q, col_d;
  logic [7:0]        row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;        // address of the next pixel taken
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              in_accept;
  logic              wr_accept;
  logic              last_pix;
  logic [7:0]        dim_m1;
  logic [DATA_W-1:0] pix;

  wb_bias_relu_sat #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W)
  ) u_bias_relu_sat (
    .acc     (in_data),
    .bias    (bias_q),
    .relu_en (relu_q),
    .pix     (pix)
  );

  // Output register can take a new pixel when empty or emptying this cycle.
  assign in_ready  = (state_q == ST_RUN) && (!mem_we_q || mem_ready);
  assign in_accept = in_valid && in_ready;
  assign wr_accept = mem_we_q && mem_ready;
  assign dim_m1    = dim_q - 8'd1;
  assign last_pix  = (col_q == dim_m1) && (row_q == dim_m1);

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_FIN);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    state_d     = state_q;
    dim_d       = dim_q;
    bias_d      = bias_q;
    relu_d      = relu_q;
    col_d       = col_q;
    row_d       = row_q;
    addr_d      = addr_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          dim_d   = out_dim;
          bias_d  = filter_bias;
          relu_d  = relu_en;
          col_d   = '0;
          row_d   = '0;
          addr_d  = out_memory_offset;
          state_d = (out_dim != 8'd0) ? ST_RUN : ST_FIN;
        end
      end
      ST_RUN: begin
        if (in_accept) begin
          // Address walks linearly; wraps naturally at 2^ADDR_W.
          addr_d = addr_q + ADDR_W'(1);
          if (col_q == dim_m1) begin
            col_d = '0;
            row_d = row_q + 8'd1;
          end else begin
            col_d = col_q + 8'd1;
          end
          if (last_pix) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (wr_accept) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Output register: a new pixel takes priority, so a simultaneous write
    // accept and pixel accept keeps mem_we high with the new contents.
    if (in_accept) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = addr_q;
      mem_wdata_d = pix;
    end else if (wr_accept) begin
      mem_we_d    = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dim_q       <= '0;
      bias_q      <= '0;
      relu_q      <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      addr_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      dim_q       <= dim_d;
      bias_q      <= bias_d;
      relu_q      <= relu_d;
      col_q       <= col_d;
      row_q       <= row_d;
      addr_q      <= addr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule : conv_writeback

// File: tb/tb_conv_writeback.sv
// -----------------------------------------------------------------------------
// tb_conv_writeback
//   Directed scoreboard bench for conv_writeback. Stimulus tasks push the
//   hand-computed expected writes into a queue; an independent negedge
//   monitor pops and compares every accepted memory write, checks that a
//   stalled write is held stable, and counts done pulses.
// -----------------------------------------------------------------------------
module tb_conv_writeback;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  out_dim = '0;
  logic [15:0] out_memory_offset = '0;
  logic [17:0] filter_bias = '0;
  logic        relu_en = 1'b0;
  logic        in_valid = 1'b0;
  logic [17:0] in_data = '0;
  logic        in_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ready = 1'b1;
  logic        busy;
  logic        done;

  wr_t         sb[$];
  logic [17:0] stim[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          done_count = 0;
  int          done_cyc = 0;
  int          last_wr_cyc = 0;
  bit          mr_toggle = 1'b0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [15:0] prev_data = '0;

  conv_writeback dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .out_dim           (out_dim),
    .out_memory_offset (out_memory_offset),
    .filter_bias       (filter_bias),
    .relu_en           (relu_en),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_ready          (in_ready),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_ready         (mem_ready),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory-side backpressure pattern, changed just after each edge.
  always @(posedge clk) begin
    #1;
    if (mr_toggle) mem_ready = ~mem_ready;
    else           mem_ready = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    wr_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_we", {31'd0, mem_we}, 32'd1);
        check("hold_addr", {16'd0, mem_addr}, {16'd0, prev_addr});
        check("hold_data", {16'd0, mem_wdata}, {16'd0, prev_data});
      end
      if (mem_we && !mem_ready) check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      if (mem_we && mem_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_write", {31'd0, mem_we}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("wr_addr", {16'd0, mem_addr}, {16'd0, e.addr});
          check("wr_data", {16'd0, mem_wdata}, {16'd0, e.data});
          last_wr_cyc = cyc;
        end
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
      prev_stall = mem_we && !mem_ready;
      prev_addr  = mem_addr;
      prev_data  = mem_wdata;
    end
  end

  task automatic exp_wr(input logic [15:0] a, input logic [15:0] d);
    sb.push_back({a, d});
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic start_frame(input logic [7:0] dim, input logic [15:0] off,
                             input logic [17:0] bias, input logic relu);
    out_dim = dim;
    out_memory_offset = off;
    filter_bias = bias;
    relu_en = relu;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_pixel(input logic [17:0] v, input bit rand_gap);
    int t;
    if (rand_gap && ($urandom_range(0, 1) == 1)) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data = v;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    int t;
    d0 = done_count;
    t = 0;
    while (done_count == d0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    #1;
    check(name, done_count - d0, 1);
  endtask

  task automatic run_frame(input logic [7:0] dim, input logic [15:0] off,
                           input logic [17:0] bias, input logic relu, input bit rand_gap);
    start_frame(dim, off, bias, relu);
    foreach (stim[i]) send_pixel(stim[i], rand_gap);
    in_valid = 1'b0;
    wait_done("frame_done", 200);
    check("sb_empty", sb.size(), 0);
  endtask

  initial begin
    int d0;
    int s;

    // Reset state
    #2;
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: dim=2, bias 100, no ReLU, saturation both ways
    stim = '{18'd5, 18'h3FF38, 18'd40000, 18'h20000};
    exp_wr(16'd500, 16'd105);
    exp_wr(16'd501, 16'hFF9C);
    exp_wr(16'd502, 16'h7FFF);
    exp_wr(16'd503, 16'h8000);
    run_frame(8'd2, 16'd500, 18'd100, 1'b0, 1'b0);
    check("t1_done_latency", done_cyc - last_wr_cyc, 1);
    check("t1_busy_after", {31'd0, busy}, 32'd0);

    // 2: same with ReLU
    exp_wr(16'd500, 16'd105);
    exp_wr(16'd501, 16'h0000);
    exp_wr(16'd502, 16'h7FFF);
    exp_wr(16'd503, 16'h0000);
    run_frame(8'd2, 16'd500, 18'd100, 1'b1, 1'b0);

    // Input offered while idle must be refused
    in_valid = 1'b1;
    in_data = 18'd77;
    @(negedge clk);
    check("idle_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // 3: dim=3, bias -5, mem_ready toggling, random input gaps
    mr_toggle = 1'b1;
    stim = '{18'd0, 18'd1, 18'd2, 18'd3, 18'h3FFFC, 18'd1000, 18'd32767, 18'd32772, 18'h38004};
    exp_wr(16'd100, 16'hFFFB);
    exp_wr(16'd101, 16'hFFFC);
    exp_wr(16'd102, 16'hFFFD);
    exp_wr(16'd103, 16'hFFFE);
    exp_wr(16'd104, 16'hFFF7);
    exp_wr(16'd105, 16'h03E3);
    exp_wr(16'd106, 16'h7FFA);
    exp_wr(16'd107, 16'h7FFF);
    exp_wr(16'd108, 16'h8000);
    run_frame(8'd3, 16'd100, 18'h3FFFB, 1'b0, 1'b1);
    mr_toggle = 1'b0;
    @(posedge clk);
    #1;

    // 4: dim=0 -> no writes, a single done pulse right after start
    d0 = done_count;
    s = cyc;
    start_frame(8'd0, 16'd300, 18'd0, 1'b0);
    wait_done("t4_done", 10);
    check("t4_done_soon", ((done_cyc - s) >= 1 && (done_cyc - s) <= 2) ? 32'd1 : 32'd0, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("t4_done_once", done_count - d0, 1);

    // 5: address wrap
    stim = '{18'd1, 18'h3FFFF, 18'd70000, 18'd7};
    exp_wr(16'hFFFE, 16'h0001);
    exp_wr(16'hFFFF, 16'h0000);
    exp_wr(16'h0000, 16'h7FFF);
    exp_wr(16'h0001, 16'h0007);
    run_frame(8'd2, 16'hFFFE, 18'd0, 1'b1, 1'b0);

    // 6: reset mid-frame, then a clean frame with an ignored start
    start_frame(8'd3, 16'd200, 18'd0, 1'b0);
    exp_wr(16'd200, 16'd10);
    exp_wr(16'd201, 16'd20);
    exp_wr(16'd202, 16'd30);
    send_pixel(18'd10, 1'b0);
    send_pixel(18'd20, 1'b0);
    send_pixel(18'd30, 1'b0);
    in_valid = 1'b0;
    d0 = done_count;
    #1;
    rst = 1'b1;
    #1;
    check("t6_rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("t6_rst_addr", {16'd0, mem_addr}, 32'd0);
    check("t6_rst_wdata", {16'd0, mem_wdata}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("t6_dropped", sb.size(), 1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t6_no_done", done_count - d0, 0);

    start_frame(8'd3, 16'd200, 18'd0, 1'b0);
    stim = '{18'd1, 18'h3FFFE, 18'd3, 18'h3FFFC, 18'd5, 18'h3FFFA, 18'd7, 18'h3FFF8, 18'd9};
    exp_wr(16'd200, 16'h0001);
    exp_wr(16'd201, 16'hFFFE);
    exp_wr(16'd202, 16'h0003);
    exp_wr(16'd203, 16'hFFFC);
    exp_wr(16'd204, 16'h0005);
    exp_wr(16'd205, 16'hFFFA);
    exp_wr(16'd206, 16'h0007);
    exp_wr(16'd207, 16'hFFF8);
    exp_wr(16'd208, 16'h0009);
    for (int i = 0; i < 9; i++) begin
      if (i == 4) begin
        in_valid = 1'b0;
        check("t6_busy_mid", {31'd0, busy}, 32'd1);
        out_dim = 8'd1;
        out_memory_offset = 16'd0;
        relu_en = 1'b1;
        filter_bias = 18'd1000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      send_pixel(stim[i], 1'b0);
    end
    in_valid = 1'b0;
    wait_done("t6_done", 200);
    check("t6_sb_empty", sb.size(), 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_conv_writeback
